id_fwd_reg: RTL and testbench
=============================

# id_fwd_reg

Parametrised decode stage for the OpenMIPS-style pipeline. It decodes the logic-immediate and R-type logic instructions, reads source operands from the register file, and resolves RAW hazards by forwarding from the EX and MEM stages. It raises a stall request on load-use hazards and registers its results into an integrated ID/EX pipeline register. It sits between the IF/ID register and the execute unit, and also keeps a saturating count of illegal instructions for debug.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width
- ALUOP_W, 8, ALU opcode width
- ALUSEL_W, 3, ALU result-select width
- CNT_W, 16, illegal-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_i  in  32  PC of instruction in ID
- inst_i  in  32  instruction in ID
- id_valid_i  in  1  inst_i is a real instruction (0 = bubble)
- reg1_data_i, reg2_data_i  in  DATA_W  register-file read data
- reg1_read_o, reg2_read_o  out  1  register-file read enables (comb.)
- reg1_addr_o, reg2_addr_o  out  REG_AW  inst_i[25:21], inst_i[20:16] (comb.)
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/REG_AW/DATA_W/1  EX-stage write-back info
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage write-back info
- stall_i  in  1  downstream hold; ID/EX register keeps its value
- stallreq_o  out  1  load-use stall request to the pipeline controller (comb.)
- ex_valid_o  out  1  registered: ex_* outputs carry a real instruction
- ex_pc_o  out  32  registered PC
- ex_aluop_o, ex_alusel_o  out  ALUOP_W/ALUSEL_W  registered ALU controls
- ex_reg1_o, ex_reg2_o  out  DATA_W  registered source operands
- ex_wd_o, ex_wreg_o  out  REG_AW/1  registered destination address and write enable
- illegal_o  out  1  registered one-cycle pulse per captured illegal instruction
- illegal_cnt_o  out  CNT_W  saturating illegal-instruction count

## Operation
- Decode (comb.), op = inst_i[31:26]:
  - ORI 001101: aluop 8'b00100101, sel 3'b001; rs read; rt written; imm zero-extended.
  - ANDI 001100: aluop 00100100; otherwise as ORI.
  - XORI 001110: aluop 00100110; otherwise as ORI.
  - LUI 001111: aluop 00100101; reg1 read disabled with operand 0; imm = {inst[15:0],16'h0}; rt written.
  - SPECIAL 000000 with inst[10:6]=0: funct 100100/100101/100110/100111 gives AND/OR/XOR/NOR (00100100/00100101/00100110/00100111). Both rs and rt are read; rd is written.
  - inst_i == 0: valid NOP, aluop 0, sel 0, no write.
  - Anything else is illegal: treated as NOP, wreg 0.
- Operand select per port, in priority order:
  1. Read disabled: use imm. For LUI port 1, use 0.
  2. Address 0: use 0.
  3. ex_wreg_i && ex_wd_i == addr: use ex_wdata_i.
  4. mem_wreg_i && mem_wd_i == addr: use mem_wdata_i.
  5. Otherwise: use regN_data_i.
- Load-use: stallreq_o = id_valid_i && ex_is_load_i && ex_wreg_i && ex_wd_i != 0 && (read1 && ex_wd_i == addr1 || read2 && ex_wd_i == addr2).
- ID/EX register update, in priority order:
  1. rst: all ex_* = 0 (aluop/sel NOP), illegal_o = 0, illegal_cnt_o = 0.
  2. stall_i: hold all ex_* outputs; illegal_o = 0.
  3. stallreq_o: capture a bubble (ex_valid_o = 0, ex_wreg_o = 0, aluop/sel 0, operands 0); illegal_o = 0.
  4. !id_valid_i: capture a bubble.
  5. Otherwise: capture the decoded instruction with ex_valid_o = 1. For an illegal instruction, set illegal_o = 1 and increment illegal_cnt_o, saturating at all-ones.

## Timing
- Combinational outputs (reg*_read_o, reg*_addr_o, stallreq_o) follow inst_i within the same cycle.
- ID/EX outputs have one-cycle latency: an instruction presented in cycle N appears on ex_* after edge N+1.
- All registered outputs are 0 after any cycle with rst=1, including a reset asserted mid-stall. The counter clears too.
- stall_i takes precedence over stallreq_o, so no bubble is inserted while held. Upstream holds inst_i whenever stallreq_o or stall_i is 1.
- EX forwarding beats MEM forwarding when both match the same address. Address 0 never forwards.
- A load-use stall lasts exactly one cycle once the load moves to MEM; MEM forwarding then supplies the value.

## Test plan
- Reset: rst=1 for 2 cycles with garbage on all inputs -> every registered output 0, illegal_cnt_o = 0.
- ORI $1,$0,0x1100, then OR $2,$1,$1 with ex_wd_i=1, ex_wdata_i=0x1100 -> ex_reg1_o = ex_reg2_o = 0x00001100, ex_wd_o = 2, aluop 00100101.
- EX and MEM both write $3 (0xAAAA vs 0x5555), then XORI $4,$3,0xFFFF -> ex_reg1_o = 0xAAAA, ex_reg2_o = 0x0000FFFF.
- Load in EX writes $5, then ANDI $6,$5,1 -> stallreq_o = 1 for one cycle and a bubble is captured (ex_valid_o = 0). The next cycle, with MEM forwarding 0x7, gives ex_reg1_o = 7.
- stall_i = 1 for 3 cycles during a LUI $7,0x1234 capture -> ex_* held with ex_reg2_o = 0x12340000; no counter change.
- 0xFFFF+2 consecutive illegal opcodes (op 111111) -> illegal_o pulses each time, illegal_cnt_o saturates at 0xFFFF, ex_wreg_o stays 0.

Source files
------------

// File: rtl/id_fwd_reg.sv
// id_fwd_reg: decode stage for the logic subset of the MIPS ISA.
// Decodes ORI/ANDI/XORI/LUI and R-type AND/OR/XOR/NOR, selects operands
// with EX/MEM forwarding, requests a stall on load-use, and registers the
// result into the ID/EX pipeline register. Also counts illegal instructions
// with a saturating counter.
//
// Pipeline control: stall_i is a downstream hold; while it is high the ID/EX
// register keeps its contents and nothing is consumed. stallreq_o asks the
// controller to hold upstream; when it is high (and stall_i is low) a bubble
// is captured and the upstream stage must present the same inst_i next cycle.
// An instruction is consumed on a rising edge with stall_i=0, stallreq_o=0
// and id_valid_i=1.
module id_fwd_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         inst_i,
  input  logic                id_valid_i,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                stall_i,
  output logic                stallreq_o,
  output logic                ex_valid_o,
  output logic [31:0]         ex_pc_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [DATA_W-1:0]   ex_reg1_o,
  output logic [DATA_W-1:0]   ex_reg2_o,
  output logic [REG_AW-1:0]   ex_wd_o,
  output logic                ex_wreg_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    illegal_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [ALUOP_W-1:0]  ALU_AND   = ALUOP_W'(8'b00100100);
  localparam logic [ALUOP_W-1:0]  ALU_OR    = ALUOP_W'(8'b00100101);
  localparam logic [ALUOP_W-1:0]  ALU_XOR   = ALUOP_W'(8'b00100110);
  localparam logic [ALUOP_W-1:0]  ALU_NOR   = ALUOP_W'(8'b00100111);
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [ALUOP_W-1:0]  w_aluop;
  logic [ALUSEL_W-1:0] w_alusel;
  logic                w_read1;
  logic                w_read2;
  logic                w_wreg;
  logic [REG_AW-1:0]   w_wd;
  logic [DATA_W-1:0]   w_imm;
  logic                w_lui;
  logic                w_illegal;
  logic [REG_AW-1:0]   w_addr1;
  logic [REG_AW-1:0]   w_addr2;
  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_op2;
  logic                w_stallreq;

  logic                r_valid;
  logic [31:0]         r_pc;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [REG_AW-1:0]   r_wd;
  logic                r_wreg;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_cnt;

  assign w_op    = inst_i[31:26];
  assign w_funct = inst_i[5:0];
  assign w_addr1 = REG_AW'(inst_i[25:21]);
  assign w_addr2 = REG_AW'(inst_i[20:16]);

  // Instruction decode: ALU controls, read enables, destination, immediate.
  always_comb begin
    w_aluop   = '0;
    w_alusel  = '0;
    w_read1   = 1'b0;
    w_read2   = 1'b0;
    w_wreg    = 1'b0;
    w_wd      = '0;
    w_imm     = '0;
    w_lui     = 1'b0;
    w_illegal = 1'b0;
    if (inst_i == 32'h0) begin
      // Canonical NOP: all defaults.
    end else begin
      case (w_op)
        OP_ORI, OP_ANDI, OP_XORI: begin
          w_aluop  = (w_op == OP_ORI)  ? ALU_OR :
                     (w_op == OP_ANDI) ? ALU_AND : ALU_XOR;
          w_alusel = SEL_LOGIC;
          w_read1  = 1'b1;
          w_wreg   = 1'b1;
          w_wd     = REG_AW'(inst_i[20:16]);
          w_imm    = DATA_W'(inst_i[15:0]);
        end
        OP_LUI: begin
          w_aluop  = ALU_OR;
          w_alusel = SEL_LOGIC;
          w_lui    = 1'b1;
          w_wreg   = 1'b1;
          w_wd     = REG_AW'(inst_i[20:16]);
          w_imm    = DATA_W'({inst_i[15:0], 16'h0000});
        end
        OP_SPECIAL: begin
          if (inst_i[10:6] == 5'd0 && w_funct[5:2] == 4'b1001) begin
            case (w_funct[1:0])
              2'b00:   w_aluop = ALU_AND;
              2'b01:   w_aluop = ALU_OR;
              2'b10:   w_aluop = ALU_XOR;
              default: w_aluop = ALU_NOR;
            endcase
            w_alusel = SEL_LOGIC;
            w_read1  = 1'b1;
            w_read2  = 1'b1;
            w_wreg   = 1'b1;
            w_wd     = REG_AW'(inst_i[15:11]);
          end else begin
            w_illegal = 1'b1;
          end
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // Port 1 operand: immediate/zero when not read, else $0, EX, MEM, regfile.
  always_comb begin
    w_op1 = reg1_data_i;
    if (!w_read1)                               w_op1 = w_lui ? '0 : w_imm;
    else if (w_addr1 == '0)                     w_op1 = '0;
    else if (ex_wreg_i && ex_wd_i == w_addr1)   w_op1 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == w_addr1) w_op1 = mem_wdata_i;
  end

  // Port 2 operand: same priority as port 1; unread port carries the immediate.
  always_comb begin
    w_op2 = reg2_data_i;
    if (!w_read2)                               w_op2 = w_imm;
    else if (w_addr2 == '0)                     w_op2 = '0;
    else if (ex_wreg_i && ex_wd_i == w_addr2)   w_op2 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == w_addr2) w_op2 = mem_wdata_i;
  end

  // Load-use hazard: the EX-stage load result is not available until MEM.
  always_comb begin
    w_stallreq = id_valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                 ((w_read1 && ex_wd_i == w_addr1) || (w_read2 && ex_wd_i == w_addr2));
  end

  // ID/EX pipeline register with hold, bubble insertion and illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_aluop   <= '0;
      r_alusel  <= '0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (stall_i) begin
      r_illegal <= 1'b0;
    end else if (w_stallreq || !id_valid_i) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_aluop   <= '0;
      r_alusel  <= '0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid   <= 1'b1;
      r_pc      <= pc_i;
      r_aluop   <= w_aluop;
      r_alusel  <= w_alusel;
      r_reg1    <= w_op1;
      r_reg2    <= w_op2;
      r_wd      <= w_wd;
      r_wreg    <= w_wreg;
      r_illegal <= w_illegal;
      if (w_illegal && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign reg1_read_o   = w_read1;
  assign reg2_read_o   = w_read2;
  assign reg1_addr_o   = w_addr1;
  assign reg2_addr_o   = w_addr2;
  assign stallreq_o    = w_stallreq;
  assign ex_valid_o    = r_valid;
  assign ex_pc_o       = r_pc;
  assign ex_aluop_o    = r_aluop;
  assign ex_alusel_o   = r_alusel;
  assign ex_reg1_o     = r_reg1;
  assign ex_reg2_o     = r_reg2;
  assign ex_wd_o       = r_wd;
  assign ex_wreg_o     = r_wreg;
  assign illegal_o     = r_illegal;
  assign illegal_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_fwd_reg.sv
// tb_id_fwd_reg: directed vector table plus multi-cycle sequences for
// load-use, downstream hold, mid-hold reset and counter saturation.
module tb_id_fwd_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        id_valid_i;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_is_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        stall_i;
  logic        stallreq_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o;
  logic        illegal_o;
  logic [15:0] illegal_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  id_fwd_reg dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .id_valid_i(id_valid_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stall_i(stall_i), .stallreq_o(stallreq_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
    .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic [31:0] r1, r2;
    logic        exw;
    logic [4:0]  exwd;
    logic [31:0] exd;
    logic        exld;
    logic        memw;
    logic [4:0]  memwd;
    logic [31:0] memd;
    logic        e_rd1, e_rd2, e_sreq, e_valid;
    logic [7:0]  e_aluop;
    logic [2:0]  e_sel;
    logic [31:0] e_r1, e_r2;
    logic [4:0]  e_wd;
    logic        e_wreg, e_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    pc_i = 32'h0; inst_i = 32'h0; id_valid_i = 1'b0;
    reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
    stall_i = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v, input logic [31:0] pc);
    pc_i = pc; inst_i = v.inst; id_valid_i = v.valid;
    reg1_data_i = v.r1; reg2_data_i = v.r2;
    ex_wreg_i = v.exw; ex_wd_i = v.exwd; ex_wdata_i = v.exd; ex_is_load_i = v.exld;
    mem_wreg_i = v.memw; mem_wd_i = v.memwd; mem_wdata_i = v.memd;
  endtask

  task automatic chk_regs(input string tag, input logic valid, input logic [31:0] pc,
                          input logic [7:0] aluop, input logic [2:0] sel,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wreg, input logic ill,
                          input logic [15:0] cnt);
    chk({tag, ".ex_valid"}, 64'(ex_valid_o), 64'(valid));
    chk({tag, ".ex_pc"}, 64'(ex_pc_o), 64'(pc));
    chk({tag, ".ex_aluop"}, 64'(ex_aluop_o), 64'(aluop));
    chk({tag, ".ex_alusel"}, 64'(ex_alusel_o), 64'(sel));
    chk({tag, ".ex_reg1"}, 64'(ex_reg1_o), 64'(r1));
    chk({tag, ".ex_reg2"}, 64'(ex_reg2_o), 64'(r2));
    chk({tag, ".ex_wd"}, 64'(ex_wd_o), 64'(wd));
    chk({tag, ".ex_wreg"}, 64'(ex_wreg_o), 64'(wreg));
    chk({tag, ".illegal"}, 64'(illegal_o), 64'(ill));
    chk({tag, ".illegal_cnt"}, 64'(illegal_cnt_o), 64'(cnt));
  endtask

  initial begin
    // Reset with garbage on every input
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      pc_i = $urandom; inst_i = $urandom; id_valid_i = 1'($urandom_range(0, 1));
      reg1_data_i = $urandom; reg2_data_i = $urandom;
      ex_wreg_i = 1'($urandom_range(0, 1)); ex_wd_i = 5'($urandom_range(0, 31));
      ex_wdata_i = $urandom; ex_is_load_i = 1'($urandom_range(0, 1));
      mem_wreg_i = 1'($urandom_range(0, 1)); mem_wd_i = 5'($urandom_range(0, 31));
      mem_wdata_i = $urandom; stall_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk_regs("reset", 1'b0, 32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    exp_cnt = 16'h0;

    // Vector table
    // ORI $1,$0,0x1100
    vecs.push_back('{32'h34011100, 1'b1, 32'h0BAD0001, 32'h0BAD0002, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1'b1, 1'b0});
    // OR $2,$1,$1 with EX forwarding $1
    vecs.push_back('{32'h00211025, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 5'd1, 32'h1100, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 8'h25, 3'd1, 32'h1100, 32'h1100, 5'd2, 1'b1, 1'b0});
    // XORI $4,$3,0xFFFF; EX and MEM both write $3, EX wins
    vecs.push_back('{32'h3864FFFF, 1'b1, 32'h1111, 32'h2222, 1'b1, 5'd3, 32'hAAAA, 1'b0, 1'b1, 5'd3, 32'h5555,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h26, 3'd1, 32'hAAAA, 32'hFFFF, 5'd4, 1'b1, 1'b0});
    // ANDI $6,$5,1; MEM forwarding only
    vecs.push_back('{32'h30A60001, 1'b1, 32'h3333, 32'h0, 1'b1, 5'd9, 32'h9999, 1'b0, 1'b1, 5'd5, 32'h7,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h24, 3'd1, 32'h7, 32'h1, 5'd6, 1'b1, 1'b0});
    // AND $8,$9,$10 from register file
    vecs.push_back('{32'h012A4024, 1'b1, 32'h0F0F, 32'h00FF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 8'h24, 3'd1, 32'h0F0F, 32'h00FF, 5'd8, 1'b1, 1'b0});
    // NOR $11,$0,$12; EX writes $0, which must not forward
    vecs.push_back('{32'h000C5827, 1'b1, 32'h5A5A, 32'h1234, 1'b1, 5'd0, 32'hBAD, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 8'h27, 3'd1, 32'h0, 32'h1234, 5'd11, 1'b1, 1'b0});
    // NOP
    vecs.push_back('{32'h0, 1'b1, 32'h77, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0});
    // Illegal opcode 111111
    vecs.push_back('{32'hFC000000, 1'b1, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1});
    // OR with nonzero shamt field is illegal
    vecs.push_back('{32'h00211065, 1'b1, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1});
    // id_valid_i=0: bubble captured
    vecs.push_back('{32'h34011100, 1'b0, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0});
    // LUI $7,0x1234 with rs=3 matching EX: port 1 must stay 0
    vecs.push_back('{32'h3C671234, 1'b1, 32'hCCCC, 32'hDDDD, 1'b1, 5'd3, 32'hEEEE, 1'b0, 1'b0, 5'd0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 3'd1, 32'h0, 32'h12340000, 5'd7, 1'b1, 1'b0});
    // ORI $1,$2,5 with unrelated load in EX: no stall
    vecs.push_back('{32'h34410005, 1'b1, 32'h10, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h25, 3'd1, 32'h10, 32'h5, 5'd1, 1'b1, 1'b0});
    // ORI $1,$0,3 with load to $0 in EX: no stall
    vecs.push_back('{32'h34010003, 1'b1, 32'h50, 32'h0, 1'b1, 5'd0, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h25, 3'd1, 32'h0, 32'h3, 5'd1, 1'b1, 1'b0});
    // ANDI $6,$5,1 with load to $5 in EX: stall, bubble
    vecs.push_back('{32'h30A60001, 1'b1, 32'h3333, 32'h0, 1'b1, 5'd5, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0});
    // ORI $5,$1,2 with load to $5 (only rt, not read): no stall
    vecs.push_back('{32'h34250002, 1'b1, 32'h40, 32'h0, 1'b1, 5'd5, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h25, 3'd1, 32'h40, 32'h2, 5'd5, 1'b1, 1'b0});
    // Load-use pattern but id_valid_i=0: no stall request
    vecs.push_back('{32'h30A60001, 1'b0, 32'h3333, 32'h0, 1'b1, 5'd5, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0});
    // AND $8,$9,$10 with load to $10: stall via port 2
    vecs.push_back('{32'h012A4024, 1'b1, 32'h0F0F, 32'h00FF, 1'b1, 5'd10, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 1'b1, 1'b0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0});
    // ANDI $6,$5,1 with EX address match but no write: MEM supplies
    vecs.push_back('{32'h30A60001, 1'b1, 32'h3333, 32'h0, 1'b0, 5'd5, 32'h99, 1'b0, 1'b1, 5'd5, 32'h44,
                     1'b1, 1'b0, 1'b0, 1'b1, 8'h24, 3'd1, 32'h44, 32'h1, 5'd6, 1'b1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic [31:0] pc;
      string tag;
      v = vecs[i];
      pc = 32'h1000 + 32'(i) * 4;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive_vec(v, pc);
      #1;
      chk({tag, ".reg1_read"}, 64'(reg1_read_o), 64'(v.e_rd1));
      chk({tag, ".reg2_read"}, 64'(reg2_read_o), 64'(v.e_rd2));
      chk({tag, ".reg1_addr"}, 64'(reg1_addr_o), 64'(v.inst[25:21]));
      chk({tag, ".reg2_addr"}, 64'(reg2_addr_o), 64'(v.inst[20:16]));
      chk({tag, ".stallreq"}, 64'(stallreq_o), 64'(v.e_sreq));
      @(posedge clk); #1;
      if (v.e_ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk_regs(tag, v.e_valid, v.e_valid ? pc : 32'h0, v.e_aluop, v.e_sel, v.e_r1, v.e_r2,
               v.e_wd, v.e_wreg, v.e_ill, exp_cnt);
    end

    // Load-use: stall cycle, then MEM supplies the loaded value
    @(negedge clk);
    drive_idle();
    pc_i = 32'h2000; inst_i = 32'h30A60001; id_valid_i = 1'b1;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_wdata_i = 32'h99; ex_is_load_i = 1'b1;
    #1 chk("lu1.stallreq", 64'(stallreq_o), 64'd1);
    @(posedge clk); #1;
    chk_regs("lu1", 1'b0, 32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    @(negedge clk);
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd5; mem_wdata_i = 32'h7;
    #1 chk("lu2.stallreq", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    chk_regs("lu2", 1'b1, 32'h2000, 8'h24, 3'd1, 32'h7, 32'h1, 5'd6, 1'b1, 1'b0, exp_cnt);

    // LUI captured, then held by stall_i for 3 cycles
    @(negedge clk);
    drive_idle();
    pc_i = 32'h3000; inst_i = 32'h3C071234; id_valid_i = 1'b1;
    @(posedge clk); #1;
    chk_regs("lui", 1'b1, 32'h3000, 8'h25, 3'd1, 32'h0, 32'h12340000, 5'd7, 1'b1, 1'b0, exp_cnt);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall_i = 1'b1;
      pc_i = 32'h3004 + 32'(c) * 4;
      if (c == 1) begin
        // Load-use pending while held: no bubble may be inserted
        inst_i = 32'h30A60001;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_is_load_i = 1'b1;
      end else begin
        inst_i = 32'hFC000000;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_is_load_i = 1'b0;
      end
      @(posedge clk); #1;
      chk_regs($sformatf("hold%0d", c), 1'b1, 32'h3000, 8'h25, 3'd1, 32'h0, 32'h12340000,
               5'd7, 1'b1, 1'b0, exp_cnt);
    end

    // Reset asserted while held clears everything, counter included
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 16'h0;
    chk_regs("rst_in_hold", 1'b0, 32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, exp_cnt);

    // Consecutive illegal instructions until and past saturation
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    pc_i = 32'h4000; inst_i = 32'hFC000000; id_valid_i = 1'b1;
    for (int c = 0; c < 32'h10001; c++) begin
      @(posedge clk); #1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk("sat.illegal", 64'(illegal_o), 64'd1);
      chk("sat.cnt", 64'(illegal_cnt_o), 64'(exp_cnt));
      chk("sat.ex_wreg", 64'(ex_wreg_o), 64'd0);
    end
    chk("sat.final_cnt", 64'(illegal_cnt_o), 64'hFFFF);

    // Bubble after saturation: pulse drops, count stays
    @(negedge clk);
    id_valid_i = 1'b0;
    @(posedge clk); #1;
    chk_regs("post_sat", 1'b0, 32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
